// File: rtl/lvd_ip_core_initialization.sv
// Reset sequencer for an LVDS SERDES receiver with dynamic phase alignment.
// Latency: outputs are registered; a lock input change is acted on 2 edges after it is first sampled.
// No backpressure: the sequence is paced by the cycle counter and the synchronized lock inputs.
//
// Ports:
//   clk            system clock, all logic on the rising edge
//   reset          synchronous, active-high reset
//   rx_locked      PLL lock from the receiver IP (asynchronous, synchronized here)
//   rx_dpa_locked  DPA lock from the receiver IP (asynchronous, synchronized here)
//   pll_areset     PLL reset to the receiver IP, active-high
//   rx_reset       receiver/DPA reset, active-high
//   rx_fifo_reset  receiver FIFO reset, active-high
//   rx_cda_reset   clock-data-alignment (bitslip) reset, active-high
//
// Sequence: PLL reset -> wait for PLL lock -> DPA training -> FIFO reset ->
// CDA reset -> done. Loss of PLL lock anywhere past WAIT_LOCK restarts from
// the PLL reset; loss of DPA lock in DONE only retrains the DPA.
module lvd_ip_core_initialization #(
    parameter int PLL_RESET_CYCLES  = 8,
    parameter int LOCK_TIMEOUT      = 1024,
    parameter int FIFO_RESET_CYCLES = 4,
    parameter int CDA_RESET_CYCLES  = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic rx_locked,
    input  logic rx_dpa_locked,
    output logic pll_areset,
    output logic rx_reset,
    output logic rx_fifo_reset,
    output logic rx_cda_reset
);

    // The shared counter only has to reach (largest duration - 1).
    localparam int MAX_A   = (PLL_RESET_CYCLES > LOCK_TIMEOUT) ? PLL_RESET_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_B   = (FIFO_RESET_CYCLES > CDA_RESET_CYCLES) ? FIFO_RESET_CYCLES : CDA_RESET_CYCLES;
    localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    // Terminal counts: a state lasting N cycles leaves on the edge where cnt == N-1.
    localparam logic [CNT_W-1:0] PLL_LAST  = CNT_W'(PLL_RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] FIFO_LAST = CNT_W'(FIFO_RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] CDA_LAST  = CNT_W'(CDA_RESET_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PLL_RST   = 3'd1,
        WAIT_LOCK = 3'd2,
        DPA_TRAIN = 3'd3,
        FIFO_RST  = 3'd4,
        CDA_RST   = 3'd5,
        DONE      = 3'd6
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    // Two-flop synchronizers for the asynchronous lock indications.
    logic lk_meta;
    logic lk;
    logic dlk_meta;
    logic dlk;

    // Output values decoded from the next state, registered below.
    logic pll_areset_nxt;
    logic rx_reset_nxt;
    logic rx_fifo_reset_nxt;
    logic rx_cda_reset_nxt;

    // Next-state logic. Loss of PLL lock is tested before any counter
    // expiry so a lock drop is never masked by a state timing out.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                state_nxt = PLL_RST;
            end
            PLL_RST: begin
                if (cnt == PLL_LAST) begin
                    state_nxt = WAIT_LOCK;
                end
            end
            WAIT_LOCK: begin
                if (lk) begin
                    state_nxt = DPA_TRAIN;
                end else if (cnt == TMO_LAST) begin
                    state_nxt = PLL_RST;
                end
            end
            DPA_TRAIN: begin
                if (!lk) begin
                    state_nxt = PLL_RST;
                end else if (dlk) begin
                    state_nxt = FIFO_RST;
                end else if (cnt == TMO_LAST) begin
                    state_nxt = PLL_RST;
                end
            end
            FIFO_RST: begin
                if (!lk) begin
                    state_nxt = PLL_RST;
                end else if (cnt == FIFO_LAST) begin
                    state_nxt = CDA_RST;
                end
            end
            CDA_RST: begin
                if (!lk) begin
                    state_nxt = PLL_RST;
                end else if (cnt == CDA_LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (!lk) begin
                    state_nxt = PLL_RST;
                end else if (!dlk) begin
                    state_nxt = DPA_TRAIN;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Counter clears on every state entry and only runs in the timed states;
    // IDLE and DONE hold it at zero so it never wraps while parked.
    always_comb begin
        cnt_nxt = cnt;
        if (state_nxt != state) begin
            cnt_nxt = '0;
        end else if (state != IDLE && state != DONE) begin
            cnt_nxt = cnt + CNT_W'(1);
        end
    end

    // Outputs follow the state being entered, so they change on the same
    // edge as the transition rather than one cycle later.
    always_comb begin
        pll_areset_nxt    = 1'b0;
        rx_reset_nxt      = 1'b0;
        rx_fifo_reset_nxt = 1'b0;
        rx_cda_reset_nxt  = 1'b0;
        case (state_nxt)
            PLL_RST: begin
                pll_areset_nxt = 1'b1;
                rx_reset_nxt   = 1'b1;
            end
            WAIT_LOCK: begin
                rx_reset_nxt = 1'b1;
            end
            FIFO_RST: begin
                rx_fifo_reset_nxt = 1'b1;
            end
            CDA_RST: begin
                rx_cda_reset_nxt = 1'b1;
            end
            default: begin
                pll_areset_nxt    = 1'b0;
                rx_reset_nxt      = 1'b0;
                rx_fifo_reset_nxt = 1'b0;
                rx_cda_reset_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            lk_meta       <= 1'b0;
            lk            <= 1'b0;
            dlk_meta      <= 1'b0;
            dlk           <= 1'b0;
            pll_areset    <= 1'b0;
            rx_reset      <= 1'b0;
            rx_fifo_reset <= 1'b0;
            rx_cda_reset  <= 1'b0;
        end else begin
            lk_meta       <= rx_locked;
            lk            <= lk_meta;
            dlk_meta      <= rx_dpa_locked;
            dlk           <= dlk_meta;
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            pll_areset    <= pll_areset_nxt;
            rx_reset      <= rx_reset_nxt;
            rx_fifo_reset <= rx_fifo_reset_nxt;
            rx_cda_reset  <= rx_cda_reset_nxt;
        end
    end

endmodule

// File: tb/tb_lvd_ip_core_initialization.sv
// Testbench for lvd_ip_core_initialization.
// Latency: expected output for each edge is queued when inputs are driven and compared at the following falling edge.
// No backpressure: stimulus rows are applied back to back.
module tb_lvd_ip_core_initialization;

    logic clk = 1'b0;
    logic reset;
    logic rx_locked;
    logic rx_dpa_locked;
    logic pll_areset;
    logic rx_reset;
    logic rx_fifo_reset;
    logic rx_cda_reset;

    always #5 clk = ~clk;

    lvd_ip_core_initialization dut (
        .clk           (clk),
        .reset         (reset),
        .rx_locked     (rx_locked),
        .rx_dpa_locked (rx_dpa_locked),
        .pll_areset    (pll_areset),
        .rx_reset      (rx_reset),
        .rx_fifo_reset (rx_fifo_reset),
        .rx_cda_reset  (rx_cda_reset)
    );

    // Output patterns as {pll_areset, rx_reset, rx_fifo_reset, rx_cda_reset}.
    localparam logic [3:0] OZ = 4'b0000;  // IDLE, DPA_TRAIN, DONE
    localparam logic [3:0] OP = 4'b1100;  // PLL_RST
    localparam logic [3:0] OW = 4'b0100;  // WAIT_LOCK
    localparam logic [3:0] OF = 4'b0010;  // FIFO_RST
    localparam logic [3:0] OC = 4'b0001;  // CDA_RST

    // One row: inputs held for n edges, outputs expected after each of them.
    typedef struct {
        logic       rst;
        logic       lk;
        logic       dlk;
        logic [3:0] exp;
        int         n;
    } vec_t;

    typedef struct {
        logic [3:0] exp;
        int         row;
        int         cyc;
    } sb_t;

    vec_t rows[$];
    sb_t  exp_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic add(input logic rst, input logic lk, input logic dlk,
                       input logic [3:0] exp, input int n);
        vec_t v;
        v.rst = rst;
        v.lk  = lk;
        v.dlk = dlk;
        v.exp = exp;
        v.n   = n;
        rows.push_back(v);
    endtask

    // Monitor: compares each queued expectation at the falling edge after its rising edge.
    initial begin
        sb_t e;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({pll_areset, rx_reset, rx_fifo_reset, rx_cda_reset} !== e.exp) begin
                    errors++;
                    $display("FAIL outputs row %0d cyc %0d: got %b required %b (pll,rx,fifo,cda)",
                             e.row, e.cyc,
                             {pll_areset, rx_reset, rx_fifo_reset, rx_cda_reset}, e.exp);
                end
            end
        end
    end

    initial begin
        sb_t s;
        reset         = 1'b1;
        rx_locked     = 1'b0;
        rx_dpa_locked = 1'b0;

        // Reset, then full sequence: rx_locked 5 cycles after pll_areset falls,
        // rx_dpa_locked 10 cycles after that. Inputs change just after an edge,
        // so outputs react on the third edge after the change.
        add(1, 0, 0, OZ, 2);
        add(0, 0, 0, OP, 8);
        add(0, 0, 0, OW, 5);
        add(0, 1, 0, OW, 2);
        add(0, 1, 0, OZ, 8);
        add(0, 1, 1, OZ, 2);
        add(0, 1, 1, OF, 4);
        add(0, 1, 1, OC, 4);
        add(0, 1, 1, OZ, 20);

        // PLL lock lost in DONE: pll_areset on the third edge, then full replay.
        // DPA lock is still synchronized high, so DPA_TRAIN lasts one edge.
        add(0, 0, 1, OZ, 2);
        add(0, 0, 1, OP, 8);
        add(0, 0, 1, OW, 2);
        add(0, 1, 1, OW, 2);
        add(0, 1, 1, OZ, 1);
        add(0, 1, 1, OF, 4);
        add(0, 1, 1, OC, 4);
        add(0, 1, 1, OZ, 6);

        // DPA lock lost in DONE: no PLL reset, FIFO and CDA pulses repeat.
        add(0, 1, 0, OZ, 6);
        add(0, 1, 1, OZ, 2);
        add(0, 1, 1, OF, 4);
        add(0, 1, 1, OC, 4);
        add(0, 1, 1, OZ, 4);

        // Reset asserted two cycles into FIFO_RST aborts on that edge.
        add(1, 0, 0, OZ, 1);
        add(0, 0, 0, OP, 8);
        add(0, 0, 0, OW, 1);
        add(0, 1, 0, OW, 2);
        add(0, 1, 0, OZ, 1);
        add(0, 1, 1, OZ, 2);
        add(0, 1, 1, OF, 2);
        add(1, 0, 0, OZ, 2);
        add(0, 0, 0, OP, 8);

        // Lock timeout: pll_areset re-pulses for 8 cycles every 8+1024.
        add(0, 0, 0, OW, 1024);
        add(0, 0, 0, OP, 8);
        add(0, 0, 0, OW, 1024);
        add(0, 0, 0, OP, 8);
        add(0, 0, 0, OW, 2);

        for (int r = 0; r < rows.size(); r++) begin
            for (int c = 0; c < rows[r].n; c++) begin
                reset         = rows[r].rst;
                rx_locked     = rows[r].lk;
                rx_dpa_locked = rows[r].dlk;
                s.exp = rows[r].exp;
                s.row = r;
                s.cyc = c;
                exp_q.push_back(s);
                @(posedge clk);
                #1;
            end
        end

        // Let the monitor drain the scoreboard, bounded.
        for (int i = 0; i < 4; i++) begin
            if (exp_q.size() != 0) @(posedge clk);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
